// File: rtl/gemm_pkg.sv
// Shared types and sizing helpers for the sequential GEMM engine.
package gemm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Accumulator wide enough for N full-scale products plus a full-scale addend.
    function automatic int unsigned acc_w(input int unsigned n, input int unsigned dw);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    // LSB position of element (i,j) in a row-major flat word, (0,0) in the MSBs.
    function automatic int unsigned idx(input int unsigned i, input int unsigned j,
                                        input int unsigned n, input int unsigned w);
        return (n * n - 1 - (i * n + j)) * w;
    endfunction

endpackage

// File: rtl/gemm_mac.sv
// Single accumulator with C-element load, product accumulate and wrap/saturate result.
module gemm_mac #(
    parameter int unsigned ACC_W = 19,
    parameter int unsigned PW    = 16,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [ACC_W-1:0] load_val_i,
    input  logic             acc_en_i,
    input  logic [PW-1:0]    prod_i,
    input  logic             sat_i,
    output logic [OUT_W-1:0] elem_c_o,
    output logic             ovf_c_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum_c;

    assign sum_c = acc_q + ACC_W'(prod_i);

    // Load wins over accumulate: the final product is consumed via sum_c in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= load_val_i;
        end else if (acc_en_i) begin
            acc_q <= sum_c;
        end
    end

    assign ovf_c_o  = (sum_c >> OUT_W) != '0;
    assign elem_c_o = (sat_i && ovf_c_o) ? '1 : OUT_W'(sum_c);

endmodule

// File: rtl/gemm_seq.sv
// Sequential R = A*B + C engine: one MAC per cycle, valid/ready on both sides.
module gemm_seq
    import gemm_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned DW    = 8,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned ACC_W = acc_w(N, DW)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*N*DW-1:0]    a_in,
    input  logic [N*N*DW-1:0]    b_in,
    input  logic [N*N*DW-1:0]    c_in,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*N*OUT_W-1:0] out_data,
    output logic                 ovf,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned MW = N * N * DW;
    localparam int unsigned OW = N * N * OUT_W;

    state_e          state_q;
    logic [MW-1:0]   a_q, b_q, c_q;
    logic            sat_q;
    logic [IW-1:0]   i_q, j_q, k_q;
    logic            in_ready_q, out_valid_q, ovf_q, busy_q;
    logic [OW-1:0]   out_data_q;

    logic            accept, in_mac, last_k, last_j, last_i;
    logic [IW-1:0]   i_nx, j_nx;
    logic [DW-1:0]   a_el, b_el, c_nx_el;
    logic [PW-1:0]   prod;
    logic            mac_load;
    logic [ACC_W-1:0] mac_load_val;
    logic [OUT_W-1:0] elem_c;
    logic            elem_ovf_c;

    assign accept = in_valid && in_ready_q;
    assign in_mac = (state_q == ST_MAC);
    assign last_k = (k_q == IW'(N - 1));
    assign last_j = (j_q == IW'(N - 1));
    assign last_i = (i_q == IW'(N - 1));

    assign j_nx = last_j ? '0 : j_q + IW'(1);
    assign i_nx = last_j ? (last_i ? '0 : i_q + IW'(1)) : i_q;

    assign a_el    = a_q[idx(32'(i_q), 32'(k_q), N, DW) +: DW];
    assign b_el    = b_q[idx(32'(k_q), 32'(j_q), N, DW) +: DW];
    assign c_nx_el = c_q[idx(32'(i_nx), 32'(j_nx), N, DW) +: DW];
    assign prod    = PW'(a_el) * PW'(b_el);

    // On accept the addend comes straight from the port since c_q is loaded on the same edge.
    assign mac_load     = accept || (in_mac && last_k);
    assign mac_load_val = accept ? ACC_W'(c_in[MW-1 -: DW]) : ACC_W'(c_nx_el);

    gemm_mac #(
        .ACC_W (ACC_W),
        .PW    (PW),
        .OUT_W (OUT_W)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (mac_load),
        .load_val_i (mac_load_val),
        .acc_en_i   (in_mac),
        .prod_i     (prod),
        .sat_i      (sat_q),
        .elem_c_o   (elem_c),
        .ovf_c_o    (elem_ovf_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            sat_q       <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q        <= a_in;
                        b_q        <= b_in;
                        c_q        <= c_in;
                        sat_q      <= sat_en;
                        ovf_q      <= 1'b0;
                        i_q        <= '0;
                        j_q        <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (last_k) begin
                        out_data_q[idx(32'(i_q), 32'(j_q), N, OUT_W) +: OUT_W] <= elem_c;
                        ovf_q <= ovf_q | elem_ovf_c;
                        k_q   <= '0;
                        i_q   <= i_nx;
                        j_q   <= j_nx;
                        if (last_i && last_j) begin
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end else begin
                        k_q <= k_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gemm_seq.sv
// Directed bench for gemm_seq: N=2/OUT_W=8 vector table plus corner sequences, and an N=4/OUT_W=16 case.
module tb_gemm_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid2, in_ready2, sat_en2, out_valid2, out_ready2, ovf2, busy2;
    logic [31:0] a2, b2, c2, out2;

    logic         in_valid4, in_ready4, sat_en4, out_valid4, out_ready4, ovf4, busy4;
    logic [127:0] a4, b4, c4;
    logic [255:0] out4, exp4;

    gemm_seq #(.N(2), .DW(8), .OUT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_in(a2), .b_in(b2), .c_in(c2), .sat_en(sat_en2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out2),
        .ovf(ovf2), .busy(busy2)
    );

    gemm_seq #(.N(4), .DW(8), .OUT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a_in(a4), .b_in(b4), .c_in(c4), .sat_en(sat_en4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out4),
        .ovf(ovf4), .busy(busy4)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        sat;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    int   lat;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accept one N=2 operation, then scramble all inputs to prove they were latched.
    task automatic accept2(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic s);
        @(negedge clk);
        a2 = a; b2 = b; c2 = c; sat_en2 = s; in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0; sat_en2 = ~s; a2 = ~a; b2 = ~b; c2 = ~c;
    endtask

    task automatic wait_out2(output int n);
        n = 0;
        while (!out_valid2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release2();
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        out_ready2 = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"basic",    32'h01020304, 32'h05060708, 32'h05060708, 1'b0, 32'h181C323A, 1'b0};
        vecs[1] = '{"ovf_sat",  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[2] = '{"ovf_wrap", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h02020202, 1'b1};
        vecs[3] = '{"ident",    32'h01000001, 32'h0A141E28, 32'h01020304, 1'b0, 32'h0B16212C, 1'b0};
        vecs[4] = '{"part_sat", 32'h10000001, 32'h10010203, 32'h00000000, 1'b1, 32'hFF100203, 1'b1};
        vecs[5] = '{"max_ok",   32'h0F000000, 32'h11000000, 32'h00000001, 1'b1, 32'hFF000001, 1'b0};
        vecs[6] = '{"max_p1",   32'h0F000000, 32'h11000000, 32'h01000000, 1'b0, 32'h00000000, 1'b1};

        rst_n = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; sat_en2 = 1'b0; a2 = '0; b2 = '0; c2 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; sat_en4 = 1'b0; a4 = '0; b4 = '0; c4 = '0;
        #22;
        chk("rst_out_valid", 256'(out_valid2), 256'(1'b0));
        chk("rst_in_ready",  256'(in_ready2),  256'(1'b1));
        chk("rst_busy",      256'(busy2),      256'(1'b0));
        chk("rst_out_data",  256'(out2),       256'(32'h0));
        chk("rst_ovf",       256'(ovf2),       256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            chk({vecs[v].name, "_in_ready"}, 256'(in_ready2), 256'(1'b1));
            accept2(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].sat);
            chk({vecs[v].name, "_busy"}, 256'({busy2, in_ready2}), 256'(2'b10));
            wait_out2(lat);
            chk({vecs[v].name, "_latency"}, 256'(lat), 256'(8));
            chk({vecs[v].name, "_data"}, 256'(out2), 256'(vecs[v].exp_data));
            chk({vecs[v].name, "_ovf"}, 256'(ovf2), 256'(vecs[v].exp_ovf));
            release2();
            chk({vecs[v].name, "_idle"}, 256'({out_valid2, in_ready2}), 256'(2'b01));
        end

        // Backpressure: result held while in_valid is pulsed against a stalled consumer.
        accept2(vecs[0].a, vecs[0].b, vecs[0].c, 1'b0);
        wait_out2(lat);
        chk("bp_latency", 256'(lat), 256'(8));
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            in_valid2 = t[0];
            @(posedge clk);
            #1;
            chk("bp_hold_flags", 256'({out_valid2, in_ready2, busy2}), 256'(3'b100));
            chk("bp_hold_data", 256'(out2), 256'(32'h181C323A));
        end
        @(negedge clk);
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_simul_flags", 256'({out_valid2, in_ready2, busy2}), 256'(3'b010));
        chk("bp_simul_data", 256'(out2), 256'(32'h181C323A));
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        accept2(vecs[3].a, vecs[3].b, vecs[3].c, 1'b0);
        chk("bp_new_busy", 256'(busy2), 256'(1'b1));
        wait_out2(lat);
        chk("bp_new_data", 256'(out2), 256'(32'h0B16212C));
        release2();

        // Reset during the third MAC cycle.
        accept2(vecs[0].a, vecs[0].b, vecs[0].c, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_partial", 256'(out2), 256'(32'h1816212C));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", 256'({out_valid2, busy2, in_ready2, ovf2}), 256'(4'b0010));
        chk("mid_rst_data", 256'(out2), 256'(32'h0));
        @(negedge clk);
        rst_n = 1'b1;
        accept2(vecs[0].a, vecs[0].b, vecs[0].c, 1'b0);
        wait_out2(lat);
        chk("mid_redo_latency", 256'(lat), 256'(8));
        chk("mid_redo_data", 256'(out2), 256'(32'h181C323A));
        chk("mid_redo_ovf", 256'(ovf2), 256'(1'b0));
        release2();

        // N=4, OUT_W=16: identity * (1..16) + 1.
        exp4 = '0;
        for (int e = 0; e < 16; e++) begin
            a4[(15 - e) * 8 +: 8]  = ((e / 4) == (e % 4)) ? 8'd1 : 8'd0;
            b4[(15 - e) * 8 +: 8]  = 8'(e + 1);
            c4[(15 - e) * 8 +: 8]  = 8'd1;
            exp4[(15 - e) * 16 +: 16] = 16'(e + 2);
        end
        @(negedge clk);
        sat_en4 = 1'b0; in_valid4 = 1'b1;
        chk("n4_in_ready", 256'(in_ready4), 256'(1'b1));
        @(posedge clk);
        #1;
        in_valid4 = 1'b0; a4 = '1; b4 = '1; c4 = '1;
        chk("n4_busy", 256'(busy4), 256'(1'b1));
        lat = 0;
        while (!out_valid4 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("n4_latency", 256'(lat), 256'(64));
        chk("n4_data", out4, exp4);
        chk("n4_ovf", 256'(ovf4), 256'(1'b0));
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        chk("n4_idle", 256'({out_valid4, in_ready4}), 256'(2'b01));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
